mul_share_sched: RTL

Round-robin scheduler that shares one pipelined `array_multiplier` instance between `NUM_REQ` independent requesters. It sits between the requesters and the multiplier's `i_valid`/`A`/`B` and `o_valid`/`Z_final` ports. It accepts at most one operand pair per cycle and tracks the owner of each in-flight product with a tag pipeline matched to the multiplier latency. Each product is returned to its owner, and any mismatch between the tag pipeline and the multiplier's `o_valid` is flagged.

---
 rtl/mul_share_sched.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mul_share_sched.sv
`default_nettype none
// ============================================================================
// Module      : mul_share_sched
// Description : Round-robin scheduler that time-shares one pipelined multiplier
//               between NUM_REQ requesters and routes each product back to its owner.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_share_sched #(
    parameter int DATAWIDTH   = 4,
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 3,
    parameter int IDW         = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*DATAWIDTH-1:0]       req_a,
    input  logic [NUM_REQ*DATAWIDTH-1:0]       req_b,
    output logic [NUM_REQ-1:0]                 resp_valid,
    output logic [2*DATAWIDTH-1:0]             resp_data,
    output logic                               mul_i_valid,
    output logic [DATAWIDTH-1:0]               mul_a,
    output logic [DATAWIDTH-1:0]               mul_b,
    input  logic                               mul_o_valid,
    input  logic [2*DATAWIDTH-1:0]             mul_z,
    output logic [$clog2(MUL_LATENCY+1)-1:0]   in_flight,
    output logic                               err
);

    localparam int c_IFW = $clog2(MUL_LATENCY + 1);

    logic [IDW-1:0]       r_last_grant;
    logic                 w_grant_any;
    logic [IDW-1:0]       w_grant_id;
    logic [IDW-1:0]       w_idx;

    // Stage 0 is aligned with mul_i_valid; stage MUL_LATENCY with mul_o_valid.
    logic                 r_tag_v  [0:MUL_LATENCY];
    logic [IDW-1:0]       r_tag_id [0:MUL_LATENCY];

    logic [DATAWIDTH-1:0] r_mul_a;
    logic [DATAWIDTH-1:0] r_mul_b;
    logic [c_IFW-1:0]     r_in_flight;
    logic                 r_err;
    logic                 w_retire;

    always_comb begin
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        w_idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDW'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_grant_any && req_valid[w_idx]) begin
                w_grant_any = 1'b1;
                w_grant_id  = w_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_grant_any) begin
            req_ready[w_grant_id] = 1'b1;
        end
    end

    assign w_retire = r_tag_v[MUL_LATENCY];

    always_comb begin
        resp_valid = '0;
        if (w_retire) begin
            resp_valid[r_tag_id[MUL_LATENCY]] = 1'b1;
        end
    end

    assign resp_data   = w_retire ? mul_z : '0;
    assign mul_i_valid = r_tag_v[0];
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign in_flight   = r_in_flight;
    assign err         = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s <= MUL_LATENCY; s++) begin
                r_tag_v[s]  <= 1'b0;
                r_tag_id[s] <= '0;
            end
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_last_grant <= IDW'(NUM_REQ - 1);
            r_in_flight  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_tag_v[0]  <= w_grant_any;
            r_tag_id[0] <= w_grant_any ? w_grant_id : '0;
            for (int s = 1; s <= MUL_LATENCY; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
            if (w_grant_any) begin
                r_mul_a      <= req_a[int'(w_grant_id)*DATAWIDTH +: DATAWIDTH];
                r_mul_b      <= req_b[int'(w_grant_id)*DATAWIDTH +: DATAWIDTH];
                r_last_grant <= w_grant_id;
            end
            // Counted from the cycle the operation enters the multiplier.
            if (r_tag_v[0] && !w_retire) begin
                r_in_flight <= r_in_flight + c_IFW'(1);
            end else if (!r_tag_v[0] && w_retire) begin
                r_in_flight <= r_in_flight - c_IFW'(1);
            end
            if (w_retire != mul_o_valid) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
